// File: rtl/mpu_axi_rd_arbiter_if.sv
// AXI4 read-address and read-data channel bundle; "master" drives AR and RREADY,
// "slave" drives ARREADY and the R beat.
`timescale 1ns/1ps
interface mpu_axi_rd_arbiter_if #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ID_WIDTH   = 1
);
  logic [C_ID_WIDTH-1:0]   arid;
  logic [C_ADDR_WIDTH-1:0] araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [C_ID_WIDTH-1:0]   rid;
  logic [C_DATA_WIDTH-1:0] rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/mpu_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read path between S0/S1, one whole burst per grant; AR is
// registered (1 cycle to ARVALID), R is combinational with RREADY from the owner. MPU_RD_ARB_LEN_CHECK_EN adds a length check.
`timescale 1ns/1ps
module mpu_axi_rd_arbiter #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ID_WIDTH   = 1
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  mpu_axi_rd_arbiter_if.slave         s0_axi,
  mpu_axi_rd_arbiter_if.slave         s1_axi,
  mpu_axi_rd_arbiter_if.master        m_axi,
  output logic                        GRANT,
  output logic                        BUSY,
  output logic                        LEN_ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t                  state_q, state_d;
  logic                    rr_last_q;
  logic                    grant_q;
  logic [C_ID_WIDTH-1:0]   ar_id_q;
  logic [C_ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]              ar_len_q;
  logic [2:0]              ar_size_q;
  logic [1:0]              ar_burst_q;
  logic                    win_sel;
  logic                    take;
  logic                    r_hs;
  logic                    s0_own;
  logic                    s1_own;

  // On a tie the requester that did not own the previous burst wins.
  assign win_sel = (s0_axi.arvalid & s1_axi.arvalid) ? ~rr_last_q : s1_axi.arvalid;
  assign take    = (state_q == ST_IDLE) & (s0_axi.arvalid | s1_axi.arvalid);
  assign r_hs    = (state_q == ST_DATA) & m_axi.rvalid & m_axi.rready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (take) state_d = ST_ADDR;
      ST_ADDR: if (m_axi.arready) state_d = ST_DATA;
      ST_DATA: if (r_hs && m_axi.rlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= 1'b1;
      grant_q    <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q    <= win_sel;
        ar_id_q    <= win_sel ? s1_axi.arid    : s0_axi.arid;
        ar_addr_q  <= win_sel ? s1_axi.araddr  : s0_axi.araddr;
        ar_len_q   <= win_sel ? s1_axi.arlen   : s0_axi.arlen;
        ar_size_q  <= win_sel ? s1_axi.arsize  : s0_axi.arsize;
        ar_burst_q <= win_sel ? s1_axi.arburst : s0_axi.arburst;
      end
      if (r_hs && m_axi.rlast) rr_last_q <= grant_q;
    end
  end

  assign s0_axi.arready = take & ~win_sel;
  assign s1_axi.arready = take &  win_sel;

  assign m_axi.arvalid = (state_q == ST_ADDR);
  assign m_axi.arid    = ar_id_q;
  assign m_axi.araddr  = ar_addr_q;
  assign m_axi.arlen   = ar_len_q;
  assign m_axi.arsize  = ar_size_q;
  assign m_axi.arburst = ar_burst_q;

  // Non-owner R outputs are forced to zero so stale beats never leak across ports.
  assign s0_own = (state_q == ST_DATA) & ~grant_q;
  assign s1_own = (state_q == ST_DATA) &  grant_q;

  assign m_axi.rready  = (s0_own & s0_axi.rready) | (s1_own & s1_axi.rready);

  assign s0_axi.rvalid = s0_own & m_axi.rvalid;
  assign s0_axi.rdata  = s0_own ? m_axi.rdata : {C_DATA_WIDTH{1'b0}};
  assign s0_axi.rid    = s0_own ? m_axi.rid   : {C_ID_WIDTH{1'b0}};
  assign s0_axi.rresp  = s0_own ? m_axi.rresp : 2'b00;
  assign s0_axi.rlast  = s0_own & m_axi.rlast;

  assign s1_axi.rvalid = s1_own & m_axi.rvalid;
  assign s1_axi.rdata  = s1_own ? m_axi.rdata : {C_DATA_WIDTH{1'b0}};
  assign s1_axi.rid    = s1_own ? m_axi.rid   : {C_ID_WIDTH{1'b0}};
  assign s1_axi.rresp  = s1_own ? m_axi.rresp : 2'b00;
  assign s1_axi.rlast  = s1_own & m_axi.rlast;

  assign GRANT = grant_q;
  assign BUSY  = (state_q != ST_IDLE);

`ifdef MPU_RD_ARB_LEN_CHECK_EN
  logic [7:0] beat_cnt_q;
  logic       len_err_q;

  // Error when RLAST and "counter reached ARLEN" disagree on any accepted beat.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      beat_cnt_q <= 8'd0;
      len_err_q  <= 1'b0;
    end else begin
      if (state_q == ST_ADDR && m_axi.arready) beat_cnt_q <= 8'd0;
      else if (r_hs)                           beat_cnt_q <= beat_cnt_q + 8'd1;
      if (r_hs && (m_axi.rlast != (beat_cnt_q == ar_len_q))) len_err_q <= 1'b1;
    end
  end

  assign LEN_ERR = len_err_q;
`else
  assign LEN_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mpu_axi_rd_arbiter.sv
// Scoreboard bench for mpu_axi_rd_arbiter: expected AR grants and R beats are queued as requests are issued.
`timescale 1ns/1ps
module tb_mpu_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
`ifdef MPU_RD_ARB_LEN_CHECK_EN
  localparam logic EXP_LEN_ERR = 1'b1;
`else
  localparam logic EXP_LEN_ERR = 1'b0;
`endif

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic GRANT, BUSY, LEN_ERR;

  always #5 ACLK = ~ACLK;

  mpu_axi_rd_arbiter_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ID_WIDTH(IW)) s0_if ();
  mpu_axi_rd_arbiter_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ID_WIDTH(IW)) s1_if ();
  mpu_axi_rd_arbiter_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ID_WIDTH(IW)) m_if ();

  mpu_axi_rd_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ID_WIDTH(IW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s0_axi(s0_if), .s1_axi(s1_if), .m_axi(m_if),
    .GRANT(GRANT), .BUSY(BUSY), .LEN_ERR(LEN_ERR)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [63:0] exp_ar_q[$];
  logic [63:0] exp_beat_q[$];
  int          req_left[2];
  logic [31:0] req_addr[2];
  logic        req_id[2];
  logic [31:0] data_base;
  int          exp_idx, conn_idx;
  logic        conn_active;
  int          conn_beat, conn_len, early_last;
  logic        conn_id;
  logic [31:0] conn_base;
  int          leak, rx_cnt, last_rlast_cyc, last_gap;
  logic        hs_ar0, hs_ar1, hs_m_ar, hs_m_r, m_rlast_s, ar_id_s;
  logic [7:0]  ar_len_s;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pk_ar(input logic port, input logic id, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst, input logic [31:0] addr);
    return {17'd0, port, id, len, size, burst, addr};
  endfunction

  function automatic logic [63:0] pk_beat(input logic port, input logic last, input logic [1:0] resp,
                                          input logic id, input logic [31:0] data);
    return {27'd0, port, last, resp, id, data};
  endfunction

  task automatic new_base(input logic [31:0] b);
    data_base = b;
    exp_idx   = 0;
    conn_idx  = 0;
  endtask

  task automatic push_burst(input int port, input int len, input int nbeats);
    logic [31:0] base;
    logic        p;
    p = (port != 0);
    exp_ar_q.push_back(pk_ar(p, req_id[port], len[7:0], p ? 3'd3 : 3'd2, p ? 2'd2 : 2'd1, req_addr[port]));
    base = data_base + 32'(16 * exp_idx);
    exp_idx++;
    for (int b = 0; b < nbeats; b++)
      exp_beat_q.push_back(pk_beat(p, b == nbeats - 1, 2'(b), req_id[port], base + 32'(b)));
  endtask

  task automatic request(input int port, input logic [7:0] len, input int count);
    req_left[port] = count;
    if (port == 0) begin
      s0_if.arid = req_id[0]; s0_if.araddr = req_addr[0]; s0_if.arlen = len;
      s0_if.arsize = 3'd2; s0_if.arburst = 2'd1; s0_if.arvalid = 1'b1;
    end else begin
      s1_if.arid = req_id[1]; s1_if.araddr = req_addr[1]; s1_if.arlen = len;
      s1_if.arsize = 3'd3; s1_if.arburst = 2'd2; s1_if.arvalid = 1'b1;
    end
  endtask

  task automatic drive_conn();
    m_if.rvalid = conn_active;
    m_if.rdata  = conn_base + 32'(conn_beat);
    m_if.rlast  = conn_active && (conn_beat == conn_len);
    m_if.rid    = conn_id;
    m_if.rresp  = 2'(conn_beat);
  endtask

  task automatic mon_beat(input logic port, input logic last, input logic [1:0] resp,
                          input logic id, input logic [31:0] data);
    if (exp_beat_q.size() == 0) chk("beat_unexpected", 1, 0);
    else begin
      chk(port ? "beat_s1" : "beat_s0", pk_beat(port, last, resp, id, data), exp_beat_q.pop_front());
      rx_cnt++;
      if (last) last_rlast_cyc = cyc;
    end
  endtask

  // One clock: sample/check just after the negedge, update requester and connector models after the posedge.
  task automatic tick();
    #1;
    hs_ar0    = s0_if.arvalid & s0_if.arready;
    hs_ar1    = s1_if.arvalid & s1_if.arready;
    hs_m_ar   = m_if.arvalid & m_if.arready;
    hs_m_r    = m_if.rvalid & m_if.rready;
    m_rlast_s = m_if.rlast;
    ar_len_s  = m_if.arlen;
    ar_id_s   = m_if.arid;
    if (s0_if.rvalid === 1'b1 && (exp_beat_q.size() == 0 || exp_beat_q[0][36] !== 1'b0)) leak++;
    if (s1_if.rvalid === 1'b1 && (exp_beat_q.size() == 0 || exp_beat_q[0][36] !== 1'b1)) leak++;
    if (s0_if.rvalid && s0_if.rready) mon_beat(1'b0, s0_if.rlast, s0_if.rresp, s0_if.rid, s0_if.rdata);
    if (s1_if.rvalid && s1_if.rready) mon_beat(1'b1, s1_if.rlast, s1_if.rresp, s1_if.rid, s1_if.rdata);
    if (hs_ar0 || hs_ar1) last_gap = cyc - last_rlast_cyc;
    if (hs_m_ar) begin
      if (exp_ar_q.size() == 0) chk("ar_unexpected", 1, 0);
      else chk("ar", pk_ar(GRANT, m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst, m_if.araddr),
               exp_ar_q.pop_front());
    end
    @(posedge ACLK);
    cyc++;
    #1;
    if (hs_ar0) begin req_left[0]--; if (req_left[0] == 0) s0_if.arvalid = 1'b0; end
    if (hs_ar1) begin req_left[1]--; if (req_left[1] == 0) s1_if.arvalid = 1'b0; end
    if (hs_m_r) begin
      if (m_rlast_s) conn_active = 1'b0;
      else conn_beat++;
    end
    if (hs_m_ar) begin
      conn_active = 1'b1;
      conn_beat   = 0;
      conn_len    = (early_last > 0) ? early_last - 1 : int'(ar_len_s);
      conn_id     = ar_id_s;
      conn_base   = data_base + 32'(16 * conn_idx);
      conn_idx++;
    end
    drive_conn();
    @(negedge ACLK);
  endtask

  function automatic bit pending();
    return BUSY || exp_beat_q.size() != 0 || exp_ar_q.size() != 0 || s0_if.arvalid || s1_if.arvalid;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin tick(); n++; end while (pending() && n < budget);
    if (pending()) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic reset_checks(input string tag);
    #1;
    chk({tag, "_grant"},      GRANT, 0);
    chk({tag, "_busy"},       BUSY, 0);
    chk({tag, "_len_err"},    LEN_ERR, 0);
    chk({tag, "_m_arvalid"},  m_if.arvalid, 0);
    chk({tag, "_s0_arready"}, s0_if.arready, 0);
    chk({tag, "_s1_arready"}, s1_if.arready, 0);
    chk({tag, "_m_rready"},   m_if.rready, 0);
    chk({tag, "_s0_rvalid"},  s0_if.rvalid, 0);
    chk({tag, "_s1_rvalid"},  s1_if.rvalid, 0);
    chk({tag, "_m_araddr"},   m_if.araddr, 0);
    chk({tag, "_m_arlen"},    m_if.arlen, 0);
  endtask

  task automatic do_reset(input string tag);
    ARESET = 1'b1;
    conn_active = 1'b0;
    drive_conn();
    exp_ar_q.delete();
    exp_beat_q.delete();
    s0_if.arvalid = 1'b0;
    s1_if.arvalid = 1'b0;
    tick();
    tick();
    ARESET = 1'b0;
    reset_checks(tag);
    new_base(32'h0);
  endtask

  initial begin
    int n, r0;
    s0_if.arid = '0; s0_if.araddr = '0; s0_if.arlen = '0; s0_if.arsize = '0; s0_if.arburst = '0;
    s0_if.arvalid = 1'b0; s0_if.rready = 1'b1;
    s1_if.arid = '0; s1_if.araddr = '0; s1_if.arlen = '0; s1_if.arsize = '0; s1_if.arburst = '0;
    s1_if.arvalid = 1'b0; s1_if.rready = 1'b1;
    m_if.arready = 1'b1;
    conn_active = 1'b0; conn_beat = 0; conn_len = 0; conn_id = 1'b0; conn_base = '0;
    early_last = 0; leak = 0; rx_cnt = 0; last_rlast_cyc = 0; last_gap = 0;
    req_left[0] = 0; req_left[1] = 0;
    req_addr[0] = 32'h1000_0000; req_id[0] = 1'b0;
    req_addr[1] = 32'h2000_0100; req_id[1] = 1'b1;
    drive_conn();

    do_reset("rst");

    // Single S0 burst of 4 beats.
    new_base(32'hA0);
    push_burst(0, 3, 4);
    request(0, 8'd3, 1);
    #1;
    chk("t1_s0_arready", s0_if.arready, 1);
    chk("t1_arvalid_pre", m_if.arvalid, 0);
    tick();
    chk("t1_arvalid", m_if.arvalid, 1);
    chk("t1_araddr", m_if.araddr, 32'h1000_0000);
    chk("t1_arlen", m_if.arlen, 3);
    chk("t1_arready_pulse", s0_if.arready, 0);
    wait_idle("t1", 40);
    chk("t1_busy_fall", cyc - last_rlast_cyc, 1);
    chk("t1_leak", leak, 0);

    // Simultaneous requests right after reset: S0 first, S1 after one idle cycle.
    do_reset("t2_rst");
    new_base(32'hB00);
    push_burst(0, 1, 2);
    push_burst(1, 1, 2);
    request(0, 8'd1, 1);
    request(1, 8'd1, 1);
    wait_idle("t2", 60);
    chk("t2_gap", last_gap, 1);

    // Continuous single-beat requests from both: strict alternation.
    new_base(32'hC00);
    for (int k = 0; k < 6; k++) push_burst(k % 2, 0, 1);
    request(0, 8'd0, 3);
    request(1, 8'd0, 3);
    wait_idle("t3", 100);

    // Requester backpressure holds the beat without duplication.
    new_base(32'hD00);
    push_burst(0, 3, 4);
    request(0, 8'd3, 1);
    n = 0;
    while (s0_if.rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t4_first_beat", s0_if.rvalid, 1);
    s0_if.rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_m_rready", m_if.rready, 0);
      chk("t4_hold_data", s0_if.rdata, 32'hD00);
      chk("t4_s1_rvalid", s1_if.rvalid, 0);
    end
    s0_if.rready = 1'b1;
    wait_idle("t4", 40);
    chk("t4_leak", leak, 0);

    // Reset pulse during beat 2 of an 8-beat S1 burst, then a fresh S1 burst.
    new_base(32'hE00);
    push_burst(1, 7, 8);
    request(1, 8'd7, 1);
    r0 = rx_cnt;
    n = 0;
    while (rx_cnt < r0 + 1 && n < 30) begin tick(); n++; end
    chk("t5_beat2_vld", s1_if.rvalid, 1);
    s1_if.rready = 1'b0;
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    s1_if.rready = 1'b1;
    reset_checks("t5");
    conn_active = 1'b0;
    drive_conn();
    exp_beat_q.delete();
    exp_ar_q.delete();
    new_base(32'hF00);
    push_burst(1, 1, 2);
    request(1, 8'd1, 1);
    wait_idle("t5", 40);
    chk("len_err_clean", LEN_ERR, 0);

    // Early RLAST on beat 2 of an ARLEN=3 burst.
    new_base(32'h100);
    early_last = 2;
    push_burst(0, 3, 2);
    request(0, 8'd3, 1);
    wait_idle("t6", 40);
    early_last = 0;
    chk("t6_len_err", LEN_ERR, EXP_LEN_ERR);
    new_base(32'h200);
    push_burst(1, 0, 1);
    request(1, 8'd0, 1);
    wait_idle("t6b", 40);
    tick();
    tick();
    chk("t6_len_err_sticky", LEN_ERR, EXP_LEN_ERR);

    chk("final_leak", leak, 0);
    chk("final_beat_q", exp_beat_q.size(), 0);
    chk("final_ar_q", exp_ar_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mpu_axi_rd_arbiter.md
Name: mpu_axi_rd_arbiter

Overview:
- Two-requester, round-robin arbiter that shares one AXI4 read path (AR + R channels) into the MPU's AXI-to-AXI connector slave port.
- Sits between two MPU read engines (S0, S1) and the connector.
- Grants one full burst at a time: the AR beat is registered, then R beats are forwarded until RLAST completes.
- Write channels are not handled by this block.

Parameters:
- C_ADDR_WIDTH, 32, AR address width.
- C_DATA_WIDTH, 32, R data width.
- C_ID_WIDTH, 1, ARID/RID width, passed through unchanged.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- S0_AXI_ARID / S1_AXI_ARID  in  C_ID_WIDTH  requester read ID
- S0_AXI_ARADDR / S1_AXI_ARADDR  in  C_ADDR_WIDTH  burst address
- S0_AXI_ARLEN / S1_AXI_ARLEN  in  8  beats-1
- S0_AXI_ARSIZE / S1_AXI_ARSIZE  in  3  beat size
- S0_AXI_ARBURST / S1_AXI_ARBURST  in  2  burst type
- S0_AXI_ARVALID / S1_AXI_ARVALID  in  1  address valid
- S0_AXI_ARREADY / S1_AXI_ARREADY  out  1  address accepted
- S0_AXI_RID / S1_AXI_RID  out  C_ID_WIDTH  read ID
- S0_AXI_RDATA / S1_AXI_RDATA  out  C_DATA_WIDTH  read data
- S0_AXI_RRESP / S1_AXI_RRESP  out  2  response
- S0_AXI_RLAST / S1_AXI_RLAST  out  1  last beat
- S0_AXI_RVALID / S1_AXI_RVALID  out  1  data valid
- S0_AXI_RREADY / S1_AXI_RREADY  in  1  data ready
- M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST  out  as above  registered AR to connector
- M_AXI_ARVALID  out  1  registered
- M_AXI_ARREADY  in  1  connector accepts AR
- M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID  in  as above  from connector
- M_AXI_RREADY  out  1  to connector
- GRANT  out  1  owner of current burst (0 = S0, 1 = S1)
- BUSY  out  1  burst in progress
- LEN_ERR  out  1  sticky burst-length error (see Optional Feature)

Behaviour:
- Clock and reset: single clock ACLK; ARESET is synchronous, active-high.
- Reset:
  - State = IDLE; rr_last = 1, so S0 has priority after reset.
  - M_AXI_ARVALID = 0, all S*_ARREADY = 0, all S*_RVALID = 0, M_AXI_RREADY = 0.
  - GRANT = 0, BUSY = 0, LEN_ERR = 0.
  - AR registers cleared to 0.
  - ARESET asserted mid-burst aborts the burst immediately; the next cycle is IDLE with the values above.
- State IDLE:
  - If exactly one ARVALID is high, that requester wins.
  - If both are high, the winner is the requester != rr_last.
  - On a winner, in the same cycle: assert the winner's ARREADY for exactly one cycle, capture its AR fields into the M_AXI_AR* registers, set GRANT, and go to ADDR.
  - With no ARVALID: stay in IDLE, all ARREADY = 0.
- State ADDR:
  - M_AXI_ARVALID = 1 and the AR registers are held stable.
  - On M_AXI_ARREADY = 1, drop ARVALID the next cycle and go to DATA.
  - All S*_ARREADY = 0.
- State DATA:
  - R channel is combinational passthrough.
  - Granted port: S*_R* = M_AXI_R* and M_AXI_RREADY = granted S*_RREADY.
  - Non-granted port: RVALID = 0; its RDATA/RID/RRESP/RLAST are driven 0.
  - On M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST: rr_last <= GRANT, go to IDLE.
- BUSY = (state != IDLE).
- Latency: a request in IDLE reaches M_AXI_ARVALID 1 cycle after ARVALID is sampled.
- Back-to-back: the earliest new grant is the cycle after the RLAST handshake, so there is 1 idle cycle between bursts.
- Starvation-free: under continuous requests from both ports, grants strictly alternate.
- A requester that deasserts ARVALID while the arbiter is in ADDR or DATA has no effect; the registered AR remains committed.
- ARLEN = 0: a single-beat burst, so RLAST arrives on the first beat.
- RID, RRESP and ARID are forwarded without modification.
- An R beat with RVALID while the state is not DATA is ignored: M_AXI_RREADY = 0.

Optional Feature:
- Macro: MPU_RD_ARB_LEN_CHECK_EN.
- Defined:
  - An 8-bit beat counter is cleared on entry to DATA and increments on each R handshake.
  - If RLAST arrives with counter != captured ARLEN, or counter == ARLEN without RLAST, LEN_ERR is set.
  - LEN_ERR stays set until ARESET; the burst still completes on RLAST.
- Undefined: no counter logic is built and LEN_ERR is tied to 0.

Test Plan:
- S0 only, ARADDR=0x1000_0000, ARLEN=3 -> S0_ARREADY pulses 1 cycle. M_ARADDR=0x1000_0000 and M_ARLEN=3 with ARVALID the next cycle. 4 beats 0xA0..0xA3 reach S0 only, with RLAST on the 4th. BUSY falls the cycle after RLAST.
- S0 and S1 request in the same cycle right after reset -> S0 granted first (GRANT=0); S1 granted after S0's RLAST (GRANT=1).
- Both hold ARVALID continuously for 6 bursts of ARLEN=0 -> grant order is 0,1,0,1,0,1.
- During DATA, S0_RREADY=0 for 3 cycles -> M_RREADY=0 for those cycles. The beat is held and delivered once with no duplication; S1_RVALID stays 0 throughout.
- ARESET pulsed for 1 cycle during beat 2 of an ARLEN=7 burst -> the next cycle is IDLE: all outputs at reset values and GRANT=0. A new S1 request is then granted normally.
- With MPU_RD_ARB_LEN_CHECK_EN defined: ARLEN=3 with RLAST on beat 2 -> LEN_ERR=1 and stays 1. Without the macro, LEN_ERR stays 0.
